// File: rtl/wb_stage_pkg.sv
// Shared pipeline definitions for the write-back stage: FSM state encoding
// and the architectural zero-register index.
package wb_stage_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    MISS = 1'b1
  } wb_state_t;

  localparam logic [4:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/wb_stage_load_align.sv
// Load alignment: assembles a full word from the cache read-out, or selects
// one byte and sign-extends it for byte loads.
module load_align (
  input  logic        is_byte,
  input  logic [1:0]  byte_sel,
  input  logic [7:0]  word_in [0:3],
  output logic [31:0] data_out
);

  logic signed [7:0]  byte_s;
  logic signed [31:0] byte_ext;

  // Element 0 is the most significant byte of the word.
  always_comb begin
    byte_s   = word_in[byte_sel];
    byte_ext = 32'(byte_s);
    if (is_byte) begin
      data_out = byte_ext;
    end else begin
      data_out = {word_in[0], word_in[1], word_in[2], word_in[3]};
    end
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: requests the cache for loads/stores, stalls the upstream
// pipeline on a miss, registers the write-back data and drives the register
// file write port. Counts stalled cycles with a saturating counter.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int MISS_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  valid_in,
  input  logic                  mem_read_in,
  input  logic                  mem_write_in,
  input  logic                  reg_write_in,
  input  logic                  mem_to_reg_in,
  input  logic                  is_LB_SB,
  input  logic [31:0]           alu_result,
  input  logic [1:0]            mem_block,
  input  logic [7:0]            cache_data_out [0:3],
  input  logic                  hit,
  input  logic [4:0]            rd_addr,
  input  logic                  flush,
  output logic                  cache_en,
  output logic                  stall,
  output logic                  reg_write_en,
  output logic [4:0]            reg_write_addr,
  output logic [31:0]           reg_write_data,
  output logic                  valid_out,
  output logic [MISS_CNT_W-1:0] miss_cycles
);

  wb_state_t             state_q, state_d;
  logic                  valid_q, valid_d;
  logic                  reg_write_q, reg_write_d;
  logic [4:0]            rd_q, rd_d;
  logic [31:0]           wb_data_q, wb_data_d;
  logic [MISS_CNT_W-1:0] miss_q, miss_d;
  logic [31:0]           load_data;

  // A flushed instruction never touches the cache, so it can never stall.
  assign cache_en = valid_in & (mem_read_in | mem_write_in) & ~flush;
  assign stall    = cache_en & ~hit;

  load_align u_load_align (
    .is_byte  (is_LB_SB),
    .byte_sel (mem_block),
    .word_in  (cache_data_out),
    .data_out (load_data)
  );

  // Next-state logic: flush beats stall, stall beats capture.
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    reg_write_d = reg_write_q;
    rd_d        = rd_q;
    wb_data_d   = wb_data_q;
    miss_d      = miss_q;

    case (state_q)
      RUN:     if (stall) state_d = MISS;
      MISS:    if (hit || flush) state_d = RUN;
      default: state_d = RUN;
    endcase

    if (flush) begin
      valid_d = 1'b0;
      state_d = RUN;
    end else if (stall) begin
      // Bubble into WB while MEM holds its instruction.
      valid_d = 1'b0;
    end else begin
      valid_d     = valid_in;
      reg_write_d = reg_write_in;
      rd_d        = rd_addr;
      wb_data_d   = mem_to_reg_in ? load_data : alu_result;
    end

    if (stall && (miss_q != {MISS_CNT_W{1'b1}})) begin
      miss_d = miss_q + MISS_CNT_W'(1);
    end
  end

  // Stage registers, FSM state and miss counter with asynchronous clear.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= RUN;
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      rd_q        <= ZERO_REG;
      wb_data_q   <= 32'd0;
      miss_q      <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      reg_write_q <= reg_write_d;
      rd_q        <= rd_d;
      wb_data_q   <= wb_data_d;
      miss_q      <= miss_d;
    end
  end

  assign reg_write_en   = valid_q & reg_write_q & (rd_q != ZERO_REG);
  assign reg_write_addr = rd_q;
  assign reg_write_data = wb_data_q;
  assign valid_out      = valid_q;
  assign miss_cycles    = miss_q;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: scenario tasks with inline checks plus a scoreboard
// monitor that matches every register-file write against expected writes.
module tb_wb_stage;
  import wb_stage_pkg::*;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_b = 1'b1;
  logic          valid_in, mem_read_in, mem_write_in, reg_write_in;
  logic          mem_to_reg_in, is_LB_SB, hit, flush;
  logic [31:0]   alu_result;
  logic [1:0]    mem_block;
  logic [7:0]    cache_data_out [0:3];
  logic [4:0]    rd_addr;
  logic          cache_en, stall, reg_write_en, valid_out;
  logic [4:0]    reg_write_addr;
  logic [31:0]   reg_write_data;
  logic [CW-1:0] miss_cycles;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];
  wr_t mon_e;

  wb_stage #(.MISS_CNT_W(CW)) dut (
    .clk(clk), .rst_b(rst_b), .valid_in(valid_in), .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in), .reg_write_in(reg_write_in),
    .mem_to_reg_in(mem_to_reg_in), .is_LB_SB(is_LB_SB), .alu_result(alu_result),
    .mem_block(mem_block), .cache_data_out(cache_data_out), .hit(hit),
    .rd_addr(rd_addr), .flush(flush), .cache_en(cache_en), .stall(stall),
    .reg_write_en(reg_write_en), .reg_write_addr(reg_write_addr),
    .reg_write_data(reg_write_data), .valid_out(valid_out),
    .miss_cycles(miss_cycles)
  );

  always #5 clk = ~clk;

  // Reference load model: byte n of the word lives at bits [31-8n -: 8].
  function automatic logic [31:0] model_wb(input logic m2r, input logic lb,
                                           input logic [1:0] blk,
                                           input logic [31:0] word,
                                           input logic [31:0] alu);
    logic [7:0] b;
    if (!m2r) return alu;
    if (!lb) return word;
    b = word[31 - 8*blk -: 8];
    return {{24{b[7]}}, b};
  endfunction

  // Scoreboard monitor: every write strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_b && reg_write_en === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_write addr=%0d data=%h required=no_write",
                 reg_write_addr, reg_write_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (reg_write_addr !== mon_e.addr || reg_write_data !== mon_e.data) begin
          bad++;
          $display("FAIL sb_write got addr=%0d data=%h required addr=%0d data=%h",
                   reg_write_addr, reg_write_data, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  task automatic set_word(input logic [31:0] w);
    cache_data_out[0] = w[31:24];
    cache_data_out[1] = w[23:16];
    cache_data_out[2] = w[15:8];
    cache_data_out[3] = w[7:0];
  endtask

  task automatic drive(input logic v, input logic rd, input logic wr,
                       input logic rw, input logic m2r, input logic lb,
                       input logic [1:0] blk, input logic [31:0] alu,
                       input logic [31:0] word, input logic h,
                       input logic [4:0] rda);
    valid_in = v; mem_read_in = rd; mem_write_in = wr; reg_write_in = rw;
    mem_to_reg_in = m2r; is_LB_SB = lb; mem_block = blk; alu_result = alu;
    set_word(word); hit = h; rd_addr = rda; flush = 1'b0;
  endtask

  task automatic idle;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 1'b1, 5'd0);
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic do_reset;
    idle();
    tick();
    rst_b = 1'b0;
    #2;
    rst_b = 1'b1;
    exp_q.delete();
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain pending=%0d required=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    idle();
    #1;
    rst_b = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 32'd0, 32'h0, 1'b0, 5'd3);
    #1;
    total++;
    if ({valid_out, reg_write_en, miss_cycles} !== {1'b0, 1'b0, 4'h0} || dut.state_q !== RUN) begin
      bad++;
      $display("FAIL reset_regs got valid=%b we=%b miss=%h required 0 0 0",
               valid_out, reg_write_en, miss_cycles);
    end
    total++;
    if (stall !== 1'b1 || cache_en !== 1'b1) begin
      bad++;
      $display("FAIL reset_comb got stall=%b cache_en=%b required 1 1", stall, cache_en);
    end
    sample();
    idle();
    tick();
    rst_b = 1'b1;
  endtask

  task automatic test_word_hit;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 32'h0, 32'h12345678, 1'b1, 5'd5);
    push(5'd5, 32'h12345678);
    sample();
    total++;
    if (stall !== 1'b0 || cache_en !== 1'b1) begin
      bad++;
      $display("FAIL word_hit_stall got stall=%b cache_en=%b required 0 1", stall, cache_en);
    end
    tick();
    idle();
    sample();
    total++;
    if (reg_write_en !== 1'b1 || reg_write_addr !== 5'd5 || reg_write_data !== 32'h12345678) begin
      bad++;
      $display("FAIL word_hit_write got we=%b addr=%0d data=%h required 1 5 12345678",
               reg_write_en, reg_write_addr, reg_write_data);
    end
    drain("word_hit");
  endtask

  task automatic test_lb_sign;
    logic [31:0] req [2];
    req[0] = 32'hFFFFFF9A;
    req[1] = 32'h0000007F;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 32'h0, 32'h11229A44, 1'b1, 5'd8);
    push(5'd8, model_wb(1'b1, 1'b1, 2'd2, 32'h11229A44, 32'h0));
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 32'h0, 32'h80817FFF, 1'b1, 5'd9);
    push(5'd9, model_wb(1'b1, 1'b1, 2'd2, 32'h80817FFF, 32'h0));
    for (int i = 0; i < 2; i++) begin
      sample();
      total++;
      if (reg_write_data !== req[i]) begin
        bad++;
        $display("FAIL lb_sign%0d got %h required %h", i, reg_write_data, req[i]);
      end
      tick();
      idle();
    end
    drain("lb_sign");
  endtask

  task automatic test_miss;
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 32'h0, 32'hCAFEF00D, 1'b0, 5'd12);
    push(5'd12, 32'hCAFEF00D);
    for (int i = 0; i < 3; i++) begin
      sample();
      total++;
      if (stall !== 1'b1 || valid_out !== 1'b0) begin
        bad++;
        $display("FAIL miss_cycle%0d got stall=%b valid=%b required 1 0", i, stall, valid_out);
      end
      tick();
    end
    total++;
    if (dut.state_q !== MISS) begin
      bad++;
      $display("FAIL miss_state got %0d required MISS", dut.state_q);
    end
    hit = 1'b1;
    sample();
    total++;
    if (stall !== 1'b0) begin
      bad++;
      $display("FAIL miss_release got stall=%b required 0", stall);
    end
    tick();
    idle();
    sample();
    total++;
    if (reg_write_en !== 1'b1 || miss_cycles !== 4'd3) begin
      bad++;
      $display("FAIL miss_write got we=%b miss=%0d required 1 3", reg_write_en, miss_cycles);
    end
    drain("miss");
  endtask

  task automatic test_flush_miss;
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 32'h0, 32'h55AA55AA, 1'b0, 5'd6);
    sample();
    tick();
    flush = 1'b1;
    sample();
    total++;
    if (stall !== 1'b0 || cache_en !== 1'b0) begin
      bad++;
      $display("FAIL flush_comb got stall=%b cache_en=%b required 0 0", stall, cache_en);
    end
    tick();
    idle();
    sample();
    total++;
    if (dut.state_q !== RUN || valid_out !== 1'b0 || reg_write_en !== 1'b0 || miss_cycles !== 4'd1) begin
      bad++;
      $display("FAIL flush_state got state=%0d valid=%b we=%b miss=%0d required RUN 0 0 1",
               dut.state_q, valid_out, reg_write_en, miss_cycles);
    end
    repeat (3) tick();
  endtask

  task automatic test_zero_alu;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 32'h0, 32'h01020304, 1'b1, 5'd0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'hDEADBEEF, 32'h0, 1'b0, 5'd7);
    push(5'd7, 32'hDEADBEEF);
    sample();
    total++;
    if (reg_write_en !== 1'b0 || valid_out !== 1'b1 || stall !== 1'b0) begin
      bad++;
      $display("FAIL zero_reg got we=%b valid=%b stall=%b required 0 1 0",
               reg_write_en, valid_out, stall);
    end
    tick();
    idle();
    sample();
    total++;
    if (reg_write_data !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL alu_path got %h required deadbeef", reg_write_data);
    end
    drain("zero_alu");
  endtask

  task automatic test_store;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 32'h100, 32'h0, 1'b0, 5'd4);
    for (int i = 0; i < 2; i++) begin
      sample();
      total++;
      if (stall !== 1'b1) begin
        bad++;
        $display("FAIL store_stall%0d got %b required 1", i, stall);
      end
      tick();
    end
    hit = 1'b1;
    tick();
    idle();
    sample();
    total++;
    if (valid_out !== 1'b1 || reg_write_en !== 1'b0) begin
      bad++;
      $display("FAIL store_nowrite got valid=%b we=%b required 1 0", valid_out, reg_write_en);
    end
    repeat (2) tick();
  endtask

  task automatic test_back_to_back;
    logic        lb, m2r;
    logic [1:0]  blk;
    logic [31:0] w, alu;
    logic [4:0]  rd;
    for (int i = 0; i < 12; i++) begin
      lb  = 1'($urandom_range(0, 1));
      m2r = 1'($urandom_range(0, 1));
      blk = 2'($urandom_range(0, 3));
      w   = $urandom;
      alu = $urandom;
      rd  = 5'($urandom_range(1, 31));
      drive(1'b1, m2r, 1'b0, 1'b1, m2r, lb, blk, alu, w, 1'b1, rd);
      push(rd, model_wb(m2r, lb, blk, w, alu));
      tick();
    end
    idle();
    drain("back_to_back");
  endtask

  task automatic test_saturation_reset;
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 32'h0, 32'hA5A5_0F0F, 1'b1, 5'd9);
    push(5'd9, 32'hA5A50F0F);
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 5'd10);
    repeat (20) tick();
    sample();
    total++;
    if (miss_cycles !== 4'hF || reg_write_addr !== 5'd9 || reg_write_data !== 32'hA5A50F0F) begin
      bad++;
      $display("FAIL saturate got miss=%h addr=%0d data=%h required f 9 a5a50f0f",
               miss_cycles, reg_write_addr, reg_write_data);
    end
    #2;
    rst_b = 1'b0;
    #1;
    total++;
    if ({valid_out, reg_write_en, reg_write_addr, reg_write_data, miss_cycles} !== '0 ||
        dut.state_q !== RUN || stall !== 1'b1) begin
      bad++;
      $display("FAIL async_reset got valid=%b we=%b addr=%0d data=%h miss=%h stall=%b required 0 0 0 0 0 1",
               valid_out, reg_write_en, reg_write_addr, reg_write_data, miss_cycles, stall);
    end
    idle();
    tick();
    rst_b = 1'b1;
    repeat (3) tick();
    drain("sat_reset");
  endtask

  initial begin
    idle();
    test_reset();
    test_word_hit();
    test_lb_sign();
    test_miss();
    test_flush_miss();
    test_zero_alu();
    test_store();
    test_back_to_back();
    test_saturation_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
